// File: rtl/mem_req_pkg.sv
// rtl/mem_req_pkg.sv - shared state encodings and default sizing for mem_req_ctrl
//
// Purpose: one place for the controller FSM encoding and default parameters.
// Ports: none (package).
package mem_req_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd7
  } state_t;

  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/mem_req_ctrl_sat_counter.sv
// rtl/mem_req_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts enabled cycles and sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   clr   - synchronous clear (highest priority)
//   inc   - increment enable
//   count - current value, W bits
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - pipeline-to-mem_system request adapter with error and hit statistics
//
// Purpose: accepts one load/store, issues a single Rd/Wr pulse, waits for Done,
// returns registered read data and stalls the pipeline meanwhile. Misaligned
// addresses, hung transactions and mem_err park the block in a sticky ERR state.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   req_valid/req_wr/req_addr/req_wdata - pipeline request
//   stall_out                        - pipeline hold (combinational)
//   resp_valid/resp_rdata            - one-cycle completion pulse and load data
//   err                              - sticky error flag
//   mem_Addr/mem_DataIn/mem_Rd/mem_Wr - request side of mem_system
//   mem_DataOut/mem_Done/mem_Stall/mem_CacheHit/mem_err - response side of mem_system
//   hit_count/access_count           - saturating statistics
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_wr,
  input  logic [15:0]      req_addr,
  input  logic [15:0]      req_wdata,
  output logic             stall_out,
  output logic             resp_valid,
  output logic [15:0]      resp_rdata,
  output logic             err,
  output logic [15:0]      mem_Addr,
  output logic [15:0]      mem_DataIn,
  output logic             mem_Rd,
  output logic             mem_Wr,
  input  logic [15:0]      mem_DataOut,
  input  logic             mem_Done,
  input  logic             mem_Stall,
  input  logic             mem_CacheHit,
  input  logic             mem_err,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] access_count
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  // The error fires on the cycle the counter steps onto TIMEOUT-1, so the
  // compare looks one value ahead.
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

  state_t        state;
  logic [15:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          wr_q;
  logic [TW-1:0] tcnt;
  logic          done_ok;
  logic          unused_stall;

  // mem_Stall is advisory only; Done alone moves the FSM.
  assign unused_stall = mem_Stall;

  assign mem_Addr   = addr_q;
  assign mem_DataIn = wdata_q;

  assign stall_out = ((state != ST_IDLE) && (state != ST_RESP)) ||
                     ((state == ST_IDLE) && req_valid);

  // A completion that coincides with mem_err is not a completion.
  assign done_ok = (state == ST_WAIT) && mem_Done && !mem_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      tcnt       <= '0;
      mem_Rd     <= 1'b0;
      mem_Wr     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      err        <= 1'b0;
    end else begin
      mem_Rd     <= 1'b0;
      mem_Wr     <= 1'b0;
      resp_valid <= 1'b0;
      if ((state != ST_IDLE) && mem_err) begin
        state <= ST_ERR;
        err   <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (req_valid) begin
              if (req_addr[0]) begin
                state <= ST_ERR;
                err   <= 1'b1;
              end else begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wr_q    <= req_wr;
                // Pulse is registered here so it is high exactly in ISSUE.
                mem_Rd  <= !req_wr;
                mem_Wr  <= req_wr;
                state   <= ST_ISSUE;
              end
            end
          end
          ST_ISSUE: begin
            tcnt  <= '0;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (mem_Done) begin
              resp_rdata <= wr_q ? 16'h0000 : mem_DataOut;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else if (tcnt == T_LAST) begin
              tcnt  <= tcnt + TW'(1);
              err   <= 1'b1;
              state <= ST_ERR;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          ST_RESP: begin
            state <= ST_IDLE;
          end
          ST_ERR: begin
            state <= ST_ERR;
          end
          default: begin
            state <= ST_ERR;
            err   <= 1'b1;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_access_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (done_ok),
    .count (access_count)
  );

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (done_ok && mem_CacheHit),
    .count (hit_count)
  );

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed self-checking bench for mem_req_ctrl
module tb_mem_req_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_wr;
  logic [15:0]      req_addr;
  logic [15:0]      req_wdata;
  logic             stall_out;
  logic             resp_valid;
  logic [15:0]      resp_rdata;
  logic             err;
  logic [15:0]      mem_Addr;
  logic [15:0]      mem_DataIn;
  logic             mem_Rd;
  logic             mem_Wr;
  logic [15:0]      mem_DataOut;
  logic             mem_Done;
  logic             mem_Stall;
  logic             mem_CacheHit;
  logic             mem_err;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] access_count;

  int n_cmp = 0;
  int n_err = 0;

  mem_req_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall_out    (stall_out),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .err          (err),
    .mem_Addr     (mem_Addr),
    .mem_DataIn   (mem_DataIn),
    .mem_Rd       (mem_Rd),
    .mem_Wr       (mem_Wr),
    .mem_DataOut  (mem_DataOut),
    .mem_Done     (mem_Done),
    .mem_Stall    (mem_Stall),
    .mem_CacheHit (mem_CacheHit),
    .mem_err      (mem_err),
    .hit_count    (hit_count),
    .access_count (access_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    mem_Done = 1'b0;
    mem_err = 1'b0;
    mem_CacheHit = 1'b0;
    mem_DataOut = 16'h0000;
    step();
    rst = 1'b0;
  endtask

  // Called in an IDLE cycle; Done arrives k cycles after the issue cycle.
  task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                           input logic [15:0] rd, input int k, input logic hit, input string tag);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
    repeat (k) step();
    mem_Done     = 1'b1;
    mem_DataOut  = rd;
    mem_CacheHit = hit;
    step();
    mem_Done     = 1'b0;
    mem_CacheHit = 1'b0;
    mem_DataOut  = 16'h0000;
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_resp_rdata"}, 32'(resp_rdata), wr ? 32'h0 : 32'(rd));
    step();
  endtask

  initial begin
    req_wr = 1'b0;
    req_addr = 16'h0000;
    req_wdata = 16'h0000;
    mem_Stall = 1'b0;
    do_reset();
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd_wr", {30'd0, mem_Rd, mem_Wr}, 32'd0);
    chk("rst_addr", 32'(mem_Addr), 32'd0);
    chk("rst_counts", {28'd0, hit_count, access_count}, 32'd0);

    // Aligned load, Done 3 cycles after issue.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0010;
    #1 chk("ld_stall_accept", 32'(stall_out), 32'd1);
    step(); req_valid = 1'b0;
    chk("ld_rd_issue", 32'(mem_Rd), 32'd1);
    chk("ld_wr_issue", 32'(mem_Wr), 32'd0);
    chk("ld_addr", 32'(mem_Addr), 32'h0010);
    step();
    chk("ld_rd_after", 32'(mem_Rd), 32'd0);
    chk("ld_stall_wait", 32'(stall_out), 32'd1);
    step(); step();
    mem_Done = 1'b1; mem_DataOut = 16'hBEEF;
    chk("ld_stall_done", 32'(stall_out), 32'd1);
    chk("ld_no_resp_early", 32'(resp_valid), 32'd0);
    step();
    mem_Done = 1'b0; mem_DataOut = 16'h0000;
    chk("ld_resp_valid", 32'(resp_valid), 32'd1);
    chk("ld_resp_rdata", 32'(resp_rdata), 32'hBEEF);
    chk("ld_stall_resp", 32'(stall_out), 32'd0);
    step();
    chk("ld_resp_once", 32'(resp_valid), 32'd0);
    chk("ld_access", 32'(access_count), 32'd1);
    chk("ld_hit", 32'(hit_count), 32'd0);

    // Store with hit, Done one cycle after issue.
    do_reset();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
    step(); req_valid = 1'b0;
    chk("st_wr_issue", 32'(mem_Wr), 32'd1);
    chk("st_rd_issue", 32'(mem_Rd), 32'd0);
    chk("st_datain", 32'(mem_DataIn), 32'h1234);
    step();
    chk("st_wr_after", 32'(mem_Wr), 32'd0);
    mem_Done = 1'b1; mem_CacheHit = 1'b1; mem_DataOut = 16'hFFFF;
    step();
    mem_Done = 1'b0; mem_CacheHit = 1'b0; mem_DataOut = 16'h0000;
    chk("st_resp_valid", 32'(resp_valid), 32'd1);
    chk("st_resp_rdata", 32'(resp_rdata), 32'h0);
    chk("st_hit", 32'(hit_count), 32'd1);
    chk("st_access", 32'(access_count), 32'd1);
    step();

    // Misaligned load.
    do_reset();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0021;
    #1 chk("odd_rd_accept", {30'd0, mem_Rd, mem_Wr}, 32'd0);
    step(); req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("odd_err", 32'(err), 32'd1);
      chk("odd_stall", 32'(stall_out), 32'd1);
      chk("odd_no_op", {30'd0, mem_Rd, mem_Wr}, 32'd0);
      step();
    end

    // Hung transaction: err appears 8 cycles after the issue cycle.
    do_reset();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0030;
    step(); req_valid = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      chk("to_err_early", 32'(err), 32'd0);
      chk("to_no_resp", 32'(resp_valid), 32'd0);
    end
    step();
    chk("to_err", 32'(err), 32'd1);
    chk("to_stall", 32'(stall_out), 32'd1);

    // mem_err together with mem_Done in WAIT.
    do_reset();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0040;
    step(); req_valid = 1'b0;
    step();
    mem_Done = 1'b1; mem_err = 1'b1; mem_CacheHit = 1'b1; mem_DataOut = 16'hAAAA;
    step();
    mem_Done = 1'b0; mem_err = 1'b0; mem_CacheHit = 1'b0;
    chk("me_err", 32'(err), 32'd1);
    chk("me_no_resp", 32'(resp_valid), 32'd0);
    chk("me_counts", {28'd0, hit_count, access_count}, 32'd0);
    step();
    chk("me_no_resp_late", 32'(resp_valid), 32'd0);

    // Saturation of 2-bit counters.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_access(1'b0, 16'h0100 + 16'(2 * i), 16'h0, 16'h1000 + 16'(i), 1, 1'b1, "sat");
      if (i == 1) chk("sat_access_2", 32'(access_count), 32'd2);
    end
    chk("sat_hit", 32'(hit_count), 32'd3);
    chk("sat_access", 32'(access_count), 32'd3);

    // Reset in WAIT, then a fresh load.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0050;
    step(); req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_stall", 32'(stall_out), 32'd0);
    chk("mrst_rd_wr", {30'd0, mem_Rd, mem_Wr}, 32'd0);
    chk("mrst_addr", 32'(mem_Addr), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_counts", {28'd0, hit_count, access_count}, 32'd0);
    do_access(1'b0, 16'h0060, 16'h0, 16'h5A5A, 2, 1'b0, "fresh");
    chk("fresh_access", 32'(access_count), 32'd1);
    chk("fresh_hit", 32'(hit_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
